// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the single-clock FIFO slice.
//   - Default data width and depth.
//   - Pointer and occupancy-count width derivations.
//   - Per-cycle operation record (accepted push / accepted pop).
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

    // Pointer width: enough bits to address every entry. Because DEPTH is a
    // power of two, plain binary increment wraps DEPTH-1 -> 0 for free.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: one more than the pointer so the value DEPTH fits.
    function automatic int count_bits(input int depth);
        return ptr_bits(depth) + 1;
    endfunction

    // Operations actually accepted in the current cycle, after the
    // full/empty qualification and clear priority have been applied.
    typedef struct packed {
        logic push;
        logic pop;
    } fifo_op_t;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DEPTH x WIDTH register array with one synchronous write port and one
// registered read port.
//   clock  in   rising-edge clock
//   reset  in   async active-high; clears only the read register
//   we     in   write enable (already qualified by the caller)
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (already qualified by the caller)
//   raddr  in   read address
//   rdata  out  registered read data; holds its value when re is low
// ---------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = ptr_bits(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array deliberately has no reset; clearing DEPTH words
    // buys nothing because an entry is never read before it has been written,
    // and a reset-free array maps onto plain flops or RAM without a reset tree.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: updated on the same edge the pop is accepted. When the
    // FIFO is full and a push and pop hit the same address, the non-blocking
    // read returns the old (oldest) word while the new word is written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifo_ram

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
// Synchronous single-clock first-in/first-out buffer. Rate-matches a
// producer and consumer that share one clock domain.
//   clock     in   rising-edge clock
//   reset     in   async active-high reset (pointers, count, data_out)
//   clear     in   sync flush: pointers and count to 0, storage/data_out kept
//   write     in   push request
//   read      in   pop request
//   data_in   in   word to push
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds 0 entries
//   data_out  out  registered, most recently popped word
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    localparam int AW = ptr_bits(DEPTH);
    localparam int CW = count_bits(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic     wr_req;
    logic     rd_req;
    fifo_op_t op;

    // Flags come straight from the occupancy count.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // An X (or Z) on a request line must behave as "no request" so an
    // undriven agent cannot corrupt pointers or count. Case equality gives
    // exactly that in simulation and reduces to a plain compare in synthesis.
    assign wr_req = (write === 1'b1);
    assign rd_req = (read === 1'b1);

    // Accept decisions. A pop frees a slot in the same cycle, so a push into
    // a full FIFO is allowed when a pop is accepted alongside it. A push into
    // an empty FIFO never enables a same-cycle pop: the word is not yet stored.
    // Clear outranks both requests, so neither is accepted while it is high.
    // NOTE: every signal driven from always_comb gets a default at the top so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        op = '0;
        if (!clear) begin
            op.pop  = rd_req && !empty;
            op.push = wr_req && (!full || op.pop);
        end
    end

    // Pointers and count.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values and ordering between blocks is moot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (op.push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (op.pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            unique case ({op.push, op.pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (op.push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (op.pop),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule : fifo

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo
// Self-checking bench for fifo (WIDTH=32, DEPTH=8). A queue-based reference
// model applies the FIFO rules at each rising edge; outputs are compared one
// time unit after the edge.
// ---------------------------------------------------------------------------
module tb_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             clear;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;

    int errors = 0;
    int checks = 0;

    // Reference model: contents in arrival order plus the last popped word.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_dout;

    fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .write    (write),
        .read     (read),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .data_out (data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".full"},  {31'd0, full},  {31'd0, model_q.size() == DEPTH});
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, model_q.size() == 0});
        check({tag, ".dout"},  data_out, model_dout);
    endtask

    // Apply one clock edge with the given requests, then advance the model
    // with the spec's rules and compare.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic c, input logic [WIDTH-1:0] d);
        bit do_pop;
        bit do_push;
        write   = w;
        read    = r;
        clear   = c;
        data_in = d;
        @(posedge clock);
        if (c === 1'b1) begin
            model_q.delete();
        end else begin
            do_pop  = (r === 1'b1) && (model_q.size() > 0);
            do_push = (w === 1'b1) && ((model_q.size() < DEPTH) || do_pop);
            if (do_pop)  model_dout = model_q.pop_front();
            if (do_push) model_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        write = 1'b0;
        read  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] vals [8];
        logic [WIDTH-1:0] rnd;
        vals = '{100, 150, 200, 40, 70, 65, 15, 230};

        // Reset
        idle();
        data_in    = '0;
        reset      = 1'b1;
        model_dout = '0;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // 1: three writes then three reads
        step("t1.w100", 1, 0, 0, 100);
        step("t1.w150", 1, 0, 0, 150);
        step("t1.w200", 1, 0, 0, 200);
        step("t1.r1",   0, 1, 0, 0);
        step("t1.r2",   0, 1, 0, 0);
        step("t1.r3",   0, 1, 0, 0);

        // 2: fill, overflow write dropped, drain
        foreach (vals[i]) step("t2.fill", 1, 0, 0, vals[i]);
        step("t2.over99", 1, 0, 0, 99);
        for (int i = 0; i < 8; i++) step("t2.drain", 0, 1, 0, 0);

        // 3: clear wins over a simultaneous write
        step("t3.w100", 1, 0, 0, 100);
        step("t3.w150", 1, 0, 0, 150);
        step("t3.clear", 1, 0, 1, 77);
        step("t3.w5",   1, 0, 0, 5);
        step("t3.r5",   0, 1, 0, 0);

        // 4: read on empty holds data_out; read+write on empty pushes only
        step("t4.rempty", 0, 1, 0, 0);
        step("t4.rw42",   1, 1, 0, 42);
        step("t4.r42",    0, 1, 0, 0);

        // X requests must be treated as no request
        step("t4.xw",  1, 0, 0, 11);
        step("t4.xreq", 1'bx, 1'bx, 0, 12);
        step("t4.r11", 0, 1, 0, 0);

        // 5: full + simultaneous read/write, then 20 pairs across the wrap
        foreach (vals[i]) step("t5.fill", 1, 0, 0, vals[i]);
        step("t5.rw300", 1, 1, 0, 300);
        for (int i = 0; i < 20; i++) begin
            rnd = $urandom;
            step("t5.pair", 1, 1, 0, rnd);
        end
        for (int i = 0; i < 8; i++) step("t5.drain", 0, 1, 0, 0);

        // 6: asynchronous reset between edges
        step("t6.w1", 1, 0, 0, 1234);
        step("t6.w2", 1, 0, 0, 5678);
        step("t6.r1", 0, 1, 0, 0);
        write = 1'b1;
        read  = 1'b1;
        #2 reset = 1'b1;
        model_q.delete();
        model_dout = '0;
        #1;
        check_all("t6.async");
        @(negedge clock);
        reset = 1'b0;
        step("t6.w9", 1, 0, 0, 9);
        step("t6.r9", 0, 1, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), rnd);
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer for 32-bit data words. A producer pushes words with `write` and a consumer pops them in arrival order with `read`. The block reports `full` and `empty` status flags and supports a synchronous `clear` that flushes the contents. It sits between two agents in the same clock domain as a rate-matching queue.

## Interface
Parameters:
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 8: number of entries. Must be a power of two and at least 2.

Ports:
- `clock`, input, 1 bit: the single clock; all state changes on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `clear`, input, 1 bit: synchronous flush, active-high.
- `write`, input, 1 bit: push request.
- `read`, input, 1 bit: pop request.
- `data_in`, input, WIDTH bits: word to push.
- `full`, output, 1 bit: asserted when the FIFO holds DEPTH entries.
- `empty`, output, 1 bit: asserted when the FIFO holds 0 entries.
- `data_out`, output, WIDTH bits: registered output holding the most recently popped word.

## Operation
- State:
  - Storage array of DEPTH × WIDTH.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count, log2(DEPTH)+1 bits, range 0..DEPTH.
- Flags are combinational from the count:
  - `full` = (count == DEPTH).
  - `empty` = (count == 0).
- Accepted operations:
  - Push accepted when `write` is high and (not `full`, or a pop is accepted in the same cycle). On acceptance, `data_in` is stored at the write pointer and the write pointer increments.
  - Pop accepted when `read` is high and not `empty`. On acceptance, the entry at the read pointer is loaded into `data_out` and the read pointer increments.
- Count update:
  - Increments on push only.
  - Decrements on pop only.
  - Unchanged when both are accepted, or when neither is.
- Ignored requests:
  - Write while full (without a simultaneous pop) is dropped. No state change.
  - Read while empty is dropped. `data_out` holds its value.
- Priority order:
  1. `reset` overrides everything.
  2. `clear` overrides `write` and `read`: pointers and count go to 0. `data_out` and the storage contents are unchanged.
  3. `write` and `read` apply after that.
- Undefined `write` or `read` (X) must not corrupt state. Implementations treat a non-1 value as 0.

## Timing
- Reset (asynchronous, immediate on assertion, held while high):
  - Pointers = 0, count = 0.
  - `empty` = 1, `full` = 0, `data_out` = 0.
  - Storage is not reset.
- Write latency: a word pushed at edge N is poppable from edge N+1.
  - `empty` deasserts in the cycle after the first push edge.
- Read latency: `data_out` updates on the same edge the pop is accepted and is valid one cycle after `read` is sampled high.
- `full` asserts after the DEPTH-th net push edge. `empty` asserts after the last pop edge.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap. Ordering is preserved across the wrap.
- Simultaneous read and write:
  - When full: both are accepted; `full` stays high.
  - When empty: only the push is accepted; the count becomes 1.
- Reset asserted mid-operation: all in-flight requests are discarded. Operation resumes on the first edge after deassertion.

## Structure
- Shared package `fifo_pkg`:
  - Default `WIDTH`/`DEPTH` constants.
  - Pointer and count width derivations via `$clog2`.
- One natural sub-module, `fifo_ram`:
  - DEPTH × WIDTH register array.
  - Synchronous write port; registered read port driving `data_out`.
- Pointers, count, flag logic and the accept decisions live in the top level.

## Test plan
1. Reset, then write 100, 150, 200 on three consecutive edges, then read three times → `data_out` gives 100, 150, 200 in successive cycles, and `empty` = 1 after the third read.
2. Fill from empty with 100, 150, 200, 40, 70, 65, 15, 230 → `full` = 1 after the 8th push. A further write of 99 is ignored. Eight reads return the eight values in order, and the 8th read leaves `empty` = 1.
3. Push 100 and 150, assert `clear` for one cycle together with `write`=1 and `data_in`=77 → `empty` = 1 and the count is 0. A subsequent write of 5 followed by a read returns 5.
4. Read on an empty FIFO → `data_out` holds its previous value and the flags are unchanged. Simultaneous `read` and `write` of 42 on an empty FIFO → count 1, and 42 is readable next.
5. At full, simultaneous `read`+`write` of 300 → the oldest word is popped, 300 is appended, and `full` stays 1. Run 20 push/pop pairs across the wrap → the data order is preserved.
6. Assert `reset` asynchronously mid-burst (between edges) → `empty` = 1, `full` = 0 and `data_out` = 0 immediately, and a fresh write/read then works.
